// File: rtl/elastic_pipe_stage_pkg.sv
// rtl/elastic_pipe_stage_pkg.sv - shared types, constants and age helper for the elastic pipe stage
//
// Package pipe_pkg:
//   ELASTIC_MIN_DEPTH  smallest legal buffer depth
//   active_list_id_t   active-list ID at the backend's default width
//   age_younger()      true when tag is strictly younger than ref_tag, ages measured from head
package pipe_pkg;

  localparam int ELASTIC_MIN_DEPTH = 2;
  localparam int ACTIVE_LIST_ID_W  = 5;

  typedef logic [ACTIVE_LIST_ID_W-1:0] active_list_id_t;

  // Ages are distances from the active-list head modulo 2^tag_w, so IDs that
  // have wrapped past zero still order correctly behind the head.
  function automatic logic age_younger(input logic [31:0] tag,
                                       input logic [31:0] ref_tag,
                                       input logic [31:0] head,
                                       input int unsigned tag_w);
    logic [31:0] mask;
    logic [31:0] age_tag;
    logic [31:0] age_ref;
    mask    = (tag_w >= 32) ? '1 : ((32'd1 << tag_w) - 32'd1);
    age_tag = (tag - head) & mask;
    age_ref = (ref_tag - head) & mask;
    return age_tag > age_ref;
  endfunction

endpackage

// File: rtl/elastic_pipe_stage_if.sv
// rtl/elastic_pipe_stage_if.sv - ready/valid handshake bundle carrying payload and active-list ID
//
// Signals: valid, ready, data[DATA_W], tag[TAG_W]
// Modports: master drives valid/data/tag and samples ready; slave is the mirror.
interface elastic_pipe_stage_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag;

  modport master (output valid, output data, output tag, input ready);
  modport slave  (input valid, input data, input tag, output ready);

endinterface

// File: rtl/elastic_pipe_stage_survivor.sv
// rtl/elastic_pipe_stage_survivor.sv - counts queue entries that survive a selective squash
//
// Module pipe_survivor_count (combinational, built only with ELASTIC_PIPE_SQUASH_EN):
//   tags_i[DEPTH]  entry tags in queue order, index 0 is the oldest
//   occ_i          number of valid entries in tags_i
//   squash_tag_i   mispredicted branch ID; strictly younger entries die
//   head_tag_i     active-list head, origin of the age space
//   k_o            number of leading entries that survive
`ifdef ELASTIC_PIPE_SQUASH_EN
module pipe_survivor_count
  import pipe_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic [TAG_W-1:0]         tags_i [DEPTH],
  input  logic [$clog2(DEPTH):0]   occ_i,
  input  logic [TAG_W-1:0]         squash_tag_i,
  input  logic [TAG_W-1:0]         head_tag_i,
  output logic [$clog2(DEPTH):0]   k_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entries are in program order, so the killed set is a suffix: k is the
  // index of the first killed valid entry. Scanning downwards leaves the
  // lowest such index in k_o.
  always_comb begin
    k_o = occ_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < occ_i) &&
          age_younger(32'(tags_i[i]), 32'(squash_tag_i), 32'(head_tag_i), TAG_W)) begin
        k_o = CNT_W'(i);
      end
    end
  end

endmodule
`endif

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - elastic in-order pipeline buffer with flush and age-based squash
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_if (slave)        upstream valid/ready/data/tag; ready is registered
//   m_if (master)       downstream head entry valid/ready/data/tag
//   flush               kill every entry, including a same-cycle incoming one
//   squash_valid        selective squash request
//   squash_tag          branch ID; strictly younger entries are killed
//   head_tag            oldest live active-list ID
//   count               occupancy
// Build option: ELASTIC_PIPE_SQUASH_EN enables squash; otherwise the squash
// inputs are ignored and only flush kills entries.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  elastic_pipe_stage_if.slave    s_if,
  elastic_pipe_stage_if.master   m_if,
  input  logic                   flush,
  input  logic                   squash_valid,
  input  logic [TAG_W-1:0]       squash_tag,
  input  logic [TAG_W-1:0]       head_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < ELASTIC_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("elastic_pipe_stage: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [TAG_W-1:0]  mem_tag_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  wr_addr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              wr_en;
  logic              enq, deq;
  logic [CNT_W-1:0]  keep_cnt;
  logic              in_keep;
  logic              squash_act;

  assign enq = s_if.valid && s_ready_q;
  assign deq = (count_q != '0) && m_if.ready;

`ifdef ELASTIC_PIPE_SQUASH_EN
  logic [TAG_W-1:0] q_tags [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_tags[i] = mem_tag_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  pipe_survivor_count #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_survivor (
    .tags_i       (q_tags),
    .occ_i        (count_q),
    .squash_tag_i (squash_tag),
    .head_tag_i   (head_tag),
    .k_o          (keep_cnt)
  );

  assign in_keep    = !age_younger(32'(s_if.tag), 32'(squash_tag), 32'(head_tag), TAG_W);
  assign squash_act = squash_valid;
`else
  logic unused_squash;
  assign unused_squash = ^{squash_valid, squash_tag, head_tag};
  assign keep_cnt      = count_q;
  assign in_keep       = 1'b1;
  assign squash_act    = 1'b0;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    if (flush) begin
      // The head was already offered, so a consume this cycle still retires it.
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      wr_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = '0;
    end else if (squash_act) begin
      if (count_q != '0 && keep_cnt == '0) begin
        // Head killed: everything behind it and the incoming entry are younger.
        // A downstream handshake on a killed head is a no-op.
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end else begin
        // Incoming survivor lands right behind the surviving prefix.
        wr_addr  = rd_ptr_q + PTR_W'(keep_cnt);
        wr_en    = enq && in_keep;
        wr_ptr_d = wr_addr + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = keep_cnt + CNT_W'(wr_en) - CNT_W'(deq);
      end
    end else begin
      wr_en    = enq;
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
    s_ready_d = count_d < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      assert (count_d <= CNT_W'(DEPTH));
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      if (wr_en) begin
        mem_data_q[wr_addr] <= s_if.data;
        mem_tag_q[wr_addr]  <= s_if.tag;
      end
    end
  end

  assign s_if.ready = s_ready_q;
  assign m_if.valid = (count_q != '0);
  assign m_if.data  = mem_data_q[rd_ptr_q];
  assign m_if.tag   = mem_tag_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// tb/tb_elastic_pipe_stage.sv - scoreboard bench for elastic_pipe_stage
module tb_elastic_pipe_stage;
  import pipe_pkg::*;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 2;
`ifdef ELASTIC_PIPE_SQUASH_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  squash_valid;
  logic [TAG_W-1:0]      squash_tag;
  logic [TAG_W-1:0]      head_tag;
  logic [$clog2(DEPTH):0] count;

  elastic_pipe_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) up_if ();
  elastic_pipe_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dn_if ();

  elastic_pipe_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (up_if),
    .m_if         (dn_if),
    .flush        (flush),
    .squash_valid (squash_valid),
    .squash_tag   (squash_tag),
    .head_tag     (head_tag),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rx = 0;
  bit   last_enq;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit younger(input logic [TAG_W-1:0] t);
    logic [TAG_W-1:0] age_t;
    logic [TAG_W-1:0] age_s;
    age_t = t - head_tag;
    age_s = squash_tag - head_tag;
    return age_t > age_s;
  endfunction

  task automatic drive(input bit v, input logic [TAG_W-1:0] tag, input bit rdy);
    up_if.valid = v;
    up_if.tag   = tag;
    up_if.data  = {$urandom(), $urandom()};
    dn_if.ready = rdy;
  endtask

  task automatic pop_head();
    chk("m_data", dn_if.data, sb[0].data);
    chk("m_tag_out", 64'(dn_if.tag), 64'(sb[0].tag));
    void'(sb.pop_front());
    rx++;
  endtask

  // Model one clock: predict handshakes from model occupancy, update the
  // scoreboard, then compare DUT status after the edge.
  task automatic cycle();
    bit do_enq;
    bit do_deq;
    ent_t e;
    do_enq = up_if.valid && (sb.size() < DEPTH);
    do_deq = dn_if.ready && (sb.size() != 0);
    if (!rst_n) begin
      sb.delete();
      do_enq = 1'b0;
    end else if (flush) begin
      if (do_deq) pop_head();
      sb.delete();
      do_enq = 1'b0;
    end else begin
      if (SQ_EN && squash_valid) begin
        if (sb.size() != 0 && younger(sb[0].tag)) begin
          sb.delete();
          do_deq = 1'b0;
          do_enq = 1'b0;
        end else begin
          while (sb.size() != 0 && younger(sb[sb.size()-1].tag)) void'(sb.pop_back());
          if (younger(up_if.tag)) do_enq = 1'b0;
        end
      end
      if (do_deq) pop_head();
      if (do_enq) begin
        e.data = up_if.data;
        e.tag  = up_if.tag;
        sb.push_back(e);
      end
    end
    last_enq = do_enq;
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("s_ready", 64'(up_if.ready), 64'(sb.size() < DEPTH));
    chk("m_valid", 64'(dn_if.valid), 64'(sb.size() != 0));
    if (sb.size() != 0) chk("m_tag_head", 64'(dn_if.tag), 64'(sb[0].tag));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; squash_valid = 1'b0;
    squash_tag = '0; head_tag = '0;
    drive(0, 0, 0);

    // Reset state
    cycle(); cycle();
    chk("rst_m_data", dn_if.data, 64'd0);
    chk("rst_m_tag", 64'(dn_if.tag), 64'd0);
    rst_n = 1'b1;

    // Streaming: 8 back-to-back entries, continuous m_ready
    rx = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, TAG_W'(i), 1);
      cycle();
      chk("stream_rate", 64'(rx), 64'(i));
    end
    drive(0, 0, 1);
    cycle(); cycle();
    chk("stream_total", 64'(rx), 64'd8);

    // Back-pressure: third push held until a slot frees
    rx = 0;
    drive(1, 8, 0); cycle();
    drive(1, 9, 0); cycle();
    drive(1, 10, 0); cycle();
    chk("bp_full_ready", 64'(up_if.ready), 64'd0);
    dn_if.ready = 1'b1;
    for (int n = 0; n < 8 && !last_enq; n++) cycle();
    chk("bp_accept", 64'(last_enq), 64'd1);
    up_if.valid = 1'b0;
    for (int n = 0; n < 8 && sb.size() != 0; n++) cycle();
    chk("bp_drained", 64'(rx), 64'd3);

    // Squash with wrap: head 30, queue [31,0], squash at 31 kills 0
    head_tag = 5'd30;
    drive(1, 31, 0); cycle();
    drive(1, 0, 0); cycle();
    squash_valid = 1'b1; squash_tag = 5'd31;
    drive(1, 1, 0); cycle();
    // incoming younger than squash point is dropped
    drive(1, 1, 0); cycle();
    // incoming at the squash point is kept
    squash_tag = 5'd0;
    drive(1, 0, 0); cycle();
    squash_valid = 1'b0;
    drive(0, 0, 1);
    for (int n = 0; n < 6 && sb.size() != 0; n++) cycle();

    // Squash keeps an older incoming entry, then again with head consumed
    head_tag = 5'd3;
    drive(1, 3, 0); cycle();
    squash_valid = 1'b1; squash_tag = 5'd5;
    drive(1, 4, 0); cycle();
    squash_tag = 5'd4;
    drive(0, 0, 1); cycle();
    squash_valid = 1'b0;
    for (int n = 0; n < 6 && sb.size() != 0; n++) cycle();

    // Squash that kills the head kills the whole queue
    drive(1, 5, 0); cycle();
    drive(1, 6, 0); cycle();
    squash_valid = 1'b1; squash_tag = 5'd4;
    drive(0, 0, 0); cycle();
    squash_valid = 1'b0;
    dn_if.ready = 1'b1;
    for (int n = 0; n < 6 && sb.size() != 0; n++) cycle();

    // Flush with traffic on both sides at count=2
    head_tag = 5'd0;
    drive(1, 11, 0); cycle();
    drive(1, 12, 0); cycle();
    flush = 1'b1;
    drive(1, 13, 1); cycle();
    flush = 1'b0;
    drive(0, 0, 0); cycle();

    // Mid-stream reset with count=2, then a fresh push
    drive(1, 14, 0); cycle();
    drive(1, 15, 0); cycle();
    rst_n = 1'b0;
    drive(1, 16, 1); cycle();
    chk("mrst_m_data", dn_if.data, 64'd0);
    chk("mrst_m_tag", 64'(dn_if.tag), 64'd0);
    rst_n = 1'b1;
    drive(1, 17, 0); cycle();
    chk("post_rst_push", 64'(dn_if.valid), 64'd1);
    drive(0, 0, 1);
    for (int n = 0; n < 6 && sb.size() != 0; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
